// File: rtl/iter_shifter_if.sv
// Request/response bundle for the iterative shifter: request channel in, result channel out.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
// a producer holds valid and its payload stable until that edge, and ready never depends combinationally on valid.
`timescale 1ns/1ps
interface iter_shifter_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle RV64 shift unit (SLL/SRL/SRA and word forms), shifting at most STEP bits per BUSY cycle.
// FSM IDLE -> (BUSY)* -> DONE -> IDLE; flush returns to IDLE from any state.
`timescale 1ns/1ps
module iter_shifter #(
  parameter int XLEN = 64,
  parameter int STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  iter_shifter_if.slave       io,
  output logic                busy,
  output logic [1:0]          dbg_state
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLW = 3'b011;
  localparam logic [2:0] OP_SRLW = 3'b100;
  localparam logic [2:0] OP_SRAW = 3'b101;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] val_q, val_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            in_word;
  logic            in_illegal;
  logic [XLEN-1:0] in_prep;
  logic [SHW-1:0]  in_amt;
  logic [SHW:0]    k;
  logic [XLEN-1:0] shifted;

  wire unused_src2 = ^io.in_src2;

  function automatic logic is_word(input logic [2:0] op);
    return (op == OP_SLLW) || (op == OP_SRLW) || (op == OP_SRAW);
  endfunction

  // Word results are always sign-extended from bit 31, whatever was shifted in above it.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] op, input logic [XLEN-1:0] v);
    return is_word(op) ? XLEN'($signed(v[31:0])) : v;
  endfunction

  always_comb begin
    in_word    = is_word(io.in_op);
    in_illegal = (io.in_op[2:1] == 2'b11);
    in_amt     = in_word ? SHW'(io.in_src2[4:0]) : io.in_src2[SHW-1:0];
    case (io.in_op)
      OP_SLLW, OP_SRLW: in_prep = XLEN'(io.in_src1[31:0]);
      OP_SRAW:          in_prep = XLEN'($signed(io.in_src1[31:0]));
      default:          in_prep = io.in_src1;
    endcase
  end

  // k never exceeds rem, so the STEP_W branch is dead when STEP == XLEN.
  always_comb begin
    k = ({1'b0, rem_q} >= STEP_W) ? STEP_W : {1'b0, rem_q};
    case (op_q)
      OP_SLL, OP_SLLW: shifted = val_q << k;
      OP_SRA, OP_SRAW: shifted = XLEN'($signed(val_q) >>> k);
      default:         shifted = val_q >> k;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    rem_d   = rem_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          op_d  = io.in_op;
          val_d = in_prep;
          rem_d = in_amt;
          if (in_illegal) begin
            res_d   = '0;
            state_d = S_DONE;
          end else if (in_amt == '0) begin
            res_d   = finalize(io.in_op, in_prep);
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        val_d = shifted;
        rem_d = rem_q - k[SHW-1:0];
        if (rem_d == '0) begin
          res_d   = finalize(op_q, shifted);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      val_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  assign io.in_ready   = (state_q == S_IDLE);
  assign io.out_valid  = (state_q == S_DONE);
  assign io.out_result = res_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench: STEP=8 and STEP=1 instances share one stimulus stream; each result and its latency
// is checked against hand-computed values.
`timescale 1ns/1ps
module tb_iter_shifter;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  in_op;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic        busy8, busy1;
  logic [1:0]  st8, st1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iter_shifter_if #(.XLEN(64)) if8 ();
  iter_shifter_if #(.XLEN(64)) if1 ();

  assign if8.in_valid  = in_valid;
  assign if8.in_op     = in_op;
  assign if8.in_src1   = in_src1;
  assign if8.in_src2   = in_src2;
  assign if8.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_op     = in_op;
  assign if1.in_src1   = in_src1;
  assign if1.in_src2   = in_src2;
  assign if1.out_ready = out_ready;

  iter_shifter #(.XLEN(64), .STEP(8)) u_dut8 (
    .clk(clk), .rst(rst), .flush(flush), .io(if8.slave), .busy(busy8), .dbg_state(st8)
  );
  iter_shifter #(.XLEN(64), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .io(if1.slave), .busy(busy1), .dbg_state(st1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for both units, check result/latency, optionally hold backpressure, then drain.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [63:0] s1,
                       input logic [63:0] s2, input int sh, input logic [63:0] exp, input int hold);
    int e8, e1, lat8, lat1;
    e8 = (op[2:1] == 2'b11) ? 1 : 1 + (sh + 7) / 8;
    e1 = (op[2:1] == 2'b11) ? 1 : 1 + sh;
    lat8 = 0;
    lat1 = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = op;
    in_src1   = s1;
    in_src2   = s2;
    out_ready = 1'b0;
    check_eq({tag, "_in_ready8"}, 64'(if8.in_ready), 64'd1);
    @(posedge clk);
    for (int c = 1; c <= 200 && (lat8 == 0 || lat1 == 0); c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0;
        in_op    = 3'b010;
        in_src1  = ~s1;
        in_src2  = 64'd3;
      end
      if (lat8 == 0 && if8.out_valid) begin
        lat8 = c;
        check_eq({tag, "_res8"}, if8.out_result, exp);
      end
      if (lat1 == 0 && if1.out_valid) begin
        lat1 = c;
        check_eq({tag, "_res1"}, if1.out_result, exp);
      end
    end
    check_eq({tag, "_lat8"}, 64'(lat8), 64'(e8));
    check_eq({tag, "_lat1"}, 64'(lat1), 64'(e1));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 64'(if8.out_valid), 64'd1);
      check_eq({tag, "_hold_res"}, if8.out_result, exp);
      check_eq({tag, "_hold_in_ready"}, 64'(if8.in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_idle8"}, {62'd0, if8.in_ready, if8.out_valid}, 64'b10);
    check_eq({tag, "_idle1"}, {62'd0, if1.in_ready, if1.out_valid}, 64'b10);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = 3'd0;
    in_src1   = 64'd0;
    in_src2   = 64'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 64'(if8.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(if8.out_valid), 64'd0);
    check_eq("rst_out_result", if8.out_result, 64'd0);
    check_eq("rst_busy", {62'd0, busy8, busy1}, 64'd0);
    rst = 1'b0;

    do_op("sra63",  3'b010, 64'h8000_0000_0000_0000, 64'd63, 63, 64'hFFFF_FFFF_FFFF_FFFF, 5);
    do_op("sraw",   3'b101, 64'h0000_0000_8000_0010, 64'h24, 4, 64'hFFFF_FFFF_F800_0001, 0);
    do_op("srlw",   3'b100, 64'h0000_0000_8000_0010, 64'h24, 4, 64'h0000_0000_0800_0001, 0);
    do_op("sllw",   3'b011, 64'h0000_0000_4000_0001, 64'd1, 1, 64'hFFFF_FFFF_8000_0002, 0);
    do_op("sll0",   3'b000, 64'h1234, 64'd0, 0, 64'h1234, 0);
    do_op("ill110", 3'b110, 64'hDEAD_BEEF, 64'd5, 0, 64'd0, 0);
    do_op("srl40",  3'b001, 64'hF000_0000_0000_0000, 64'd40, 40, 64'h0000_0000_00F0_0000, 0);
    do_op("sll63",  3'b000, 64'h1, 64'd63, 63, 64'h8000_0000_0000_0000, 0);
    do_op("sraw0",  3'b101, 64'h0000_0001_8000_0000, 64'h40, 0, 64'hFFFF_FFFF_8000_0000, 0);
    do_op("sll_hi", 3'b000, 64'h1, 64'h107, 7, 64'h80, 0);
    do_op("sra_pos", 3'b010, 64'h7000_0000_0000_0000, 64'd17, 17, 64'h0000_3800_0000_0000, 0);
    do_op("srlw_up", 3'b100, 64'hFFFF_FFFF_0000_0100, 64'd8, 8, 64'h1, 0);
    do_op("sllw31", 3'b011, 64'h1, 64'd31, 31, 64'hFFFF_FFFF_8000_0000, 2);

    // flush while the STEP=1 unit is mid-shift (and the STEP=8 unit already waits in DONE)
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'b001;
    in_src1  = 64'hF000_0000_0000_0000;
    in_src2  = 64'd40;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      check_eq("flush_no_valid1", 64'(if1.out_valid), 64'd0);
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_idle1", {62'd0, if1.in_ready, if1.out_valid}, 64'b10);
    check_eq("flush_state1", 64'(st1), 64'd0);
    check_eq("flush_done8", 64'(if8.out_valid), 64'd0);
    do_op("post_flush", 3'b000, 64'h3, 64'd4, 4, 64'h30, 0);

    // flush in the accept cycle drops the request
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    in_op    = 3'b000;
    in_src1  = 64'h5;
    in_src2  = 64'd0;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check_eq("flush_acc_busy", {62'd0, busy8, busy1}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("flush_acc_no_valid", {62'd0, if8.out_valid, if1.out_valid}, 64'd0);
    end

    // async reset mid-BUSY
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'b010;
    in_src1  = 64'h8000_0000_0000_0000;
    in_src2  = 64'd63;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_busy1", 64'(busy1), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_in_ready1", 64'(if1.in_ready), 64'd1);
    check_eq("arst_out_valid1", 64'(if1.out_valid), 64'd0);
    check_eq("arst_result1", if1.out_result, 64'd0);
    check_eq("arst_busy", {62'd0, busy8, busy1}, 64'd0);
    check_eq("arst_state", {60'd0, st8, st1}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("post_rst_no_valid", {62'd0, if8.out_valid, if1.out_valid}, 64'd0);
    end
    check_eq("post_rst_ready", {62'd0, if8.in_ready, if1.in_ready}, 64'b11);
    do_op("post_rst", 3'b001, 64'h100, 64'd8, 8, 64'h1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Multi-cycle iterative shift unit for the RV64 execute stage; successor to the single-cycle combinational arithmetic-right-shift path.
- Covers SLL/SRL/SRA and the word forms SLLW/SRLW/SRAW in one datapath.
- Width and per-cycle shift step are parametrised, trading latency against area.
- Valid/ready handshakes on both sides; flush input for pipeline kills.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. At XLEN=32 the word ops alias the full ops.
- STEP, 8, maximum bit positions shifted per BUSY cycle; power of two, 1..XLEN.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  abort any in-flight op; return to IDLE
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 SLLW, 100 SRLW, 101 SRAW, 11x illegal
- in_src1  in  XLEN  operand to shift
- in_src2  in  XLEN  shift amount source
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  shifted result
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset values (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0; internal registers cleared. Reset mid-op drops the op with no output.
- States: IDLE, BUSY, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- Accept happens when in_valid & in_ready in cycle T. On accept, latch the op, the operand and the remaining amount rem:
  - Full ops: rem=in_src2[SHW-1:0].
  - Word ops: rem=in_src2[4:0]; in_src2[XLEN-1:5] ignored.
- Operand preparation for word ops, done at accept:
  - SLLW: low 32 bits used.
  - SRLW: in_src1[31:0] zero-extended to XLEN.
  - SRAW: in_src1[31:0] sign-extended from bit 31.
- Illegal op: result forced to 0, go to DONE at T+1.
- rem==0: operand passes through (word ops still sign-extend bit 31), go to DONE at T+1.
- Otherwise go to BUSY at T+1. Each BUSY cycle:
  - k = min(STEP, rem); shift by k; rem -= k.
  - SRA/SRAW fill vacated bits with the operand MSB; SRL/SRLW/SLL/SLLW fill with 0.
  - rem==0 after the update -> DONE next cycle.
- Latency: out_valid first asserted at T+1+ceil(shamt/STEP). shamt=63 with STEP=8 gives T+9; with STEP=1 gives T+64.
- Word result finalisation when entering DONE: out_result = sign-extend(bits[31:0]) to XLEN.
- DONE:
  - out_result and out_valid held stable while out_ready=0.
  - out_valid & out_ready -> IDLE next cycle. The next request can be accepted in the cycle after the handshake, never in the same cycle.
- flush:
  - In any state: next state IDLE, out_valid=0 next cycle, result discarded.
  - flush in the same cycle as an accept: the request is dropped.
  - flush has priority over out_ready.
- Inputs in_op/in_src1/in_src2 are sampled only at accept; later changes have no effect.

Test Plan:
- SRA (010), XLEN=64, STEP=8, src1=0x8000_0000_0000_0000, src2=63, accepted at T -> out_valid at T+9, out_result=0xFFFF_FFFF_FFFF_FFFF.
- SRAW, src1=0x0000_0000_8000_0010, src2=0x24 (bit 5 ignored, shamt=4) -> out_result=0xFFFF_FFFF_F800_0001; SRLW with the same operands -> 0x0000_0000_0800_0001.
- SLLW, src1=0x0000_0000_4000_0001, src2=1 -> 0xFFFF_FFFF_8000_0002. SLL, src1=0x1234, src2=0 -> out_valid at T+1, out_result=0x1234.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and out_result stable throughout, in_ready=0; IDLE one cycle after out_ready=1.
- flush during BUSY (SRL by 40, STEP=1, flush at T+10) -> IDLE at T+11, no out_valid; the next request completes normally. Illegal op 110 -> out_result=0 at T+1.
- Assert rst mid-BUSY -> outputs return to reset values immediately (async); after release, in_ready=1 and no stale out_valid.
